// File: rtl/vga_pkg.sv
// vga_pkg: timing defaults and shared types for the
// framebuffer capture and VGA scanout path.
package vga_pkg;

    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_H_FP         = 16;
    localparam int DEF_H_SYNC       = 96;
    localparam int DEF_H_BP         = 48;
    localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP
                                    + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;

    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_V_FP         = 10;
    localparam int DEF_V_SYNC       = 2;
    localparam int DEF_V_BP         = 33;
    localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP
                                    + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    localparam int IMG_W = 256;
    localparam int IMG_H = 256;

    typedef logic [15:0] fb_addr_t;
    typedef logic [11:0] cnt_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [1:0] {
        H_ACT,
        H_FPO,
        H_SYN,
        H_BPO
    } h_phase_e;

    typedef enum logic [1:0] {
        V_ACT,
        V_FPO,
        V_SYN,
        V_BPO
    } v_phase_e;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic win;
    } scan_t;

    localparam scan_t SCAN_IDLE = '{
        de:  1'b0,
        hs:  1'b1,
        vs:  1'b1,
        fs:  1'b0,
        win: 1'b0
    };

    function automatic rgb12_t pack_rgb(
        input logic [3:0] r,
        input logic [3:0] g,
        input logic [3:0] b
    );
        rgb12_t c;
        c.r = r;
        c.g = g;
        c.b = b;
        return c;
    endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// vga_fb_scanout_if: renderer pixel write bus in,
// VGA DAC pins out.
interface vga_fb_scanout_if;
    import vga_pkg::*;

    logic       pix_valid;
    fb_addr_t   pix_addr;
    logic [15:0] pix_r;
    logic [15:0] pix_g;
    logic [15:0] pix_b;

    logic       vga_hs;
    logic       vga_vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_de;
    logic       frame_start;

    modport master (
        output pix_valid, pix_addr, pix_r, pix_g, pix_b,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b,
        input  vga_de, frame_start
    );

    modport slave (
        input  pix_valid, pix_addr, pix_r, pix_g, pix_b,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b,
        output vga_de, frame_start
    );

endinterface

// File: rtl/vga_fb_scanout_fb_dpram.sv
// fb_dpram: simple dual-port framebuffer RAM, one write port and
// one registered read-first read port.
module fb_dpram #(
    parameter int AW = 16,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Old contents are returned on a same-address write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: captures the renderer raster into a framebuffer and
// scans it out as VGA with the image placed in a bordered window.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int          PIX_DIV    = 4,
    parameter int          H_ACTIVE   = DEF_H_ACTIVE,
    parameter int          H_FP       = DEF_H_FP,
    parameter int          H_SYNC     = DEF_H_SYNC,
    parameter int          H_BP       = DEF_H_BP,
    parameter int          V_ACTIVE   = DEF_V_ACTIVE,
    parameter int          V_FP       = DEF_V_FP,
    parameter int          V_SYNC     = DEF_V_SYNC,
    parameter int          V_BP       = DEF_V_BP,
    parameter int          IMG_X0     = 192,
    parameter int          IMG_Y0     = 112,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic            clk,
    input  logic            rst,
    vga_fb_scanout_if.slave bus
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    localparam cnt_t H_ACT_LAST = cnt_t'(H_ACTIVE - 1);
    localparam cnt_t H_FP_LAST  = cnt_t'(H_ACTIVE + H_FP - 1);
    localparam cnt_t H_SYN_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t H_LAST     = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam cnt_t V_ACT_LAST = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t V_FP_LAST  = cnt_t'(V_ACTIVE + V_FP - 1);
    localparam cnt_t V_SYN_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam cnt_t X_LO = cnt_t'(IMG_X0);
    localparam cnt_t X_HI = cnt_t'(IMG_X0 + IMG_W);
    localparam cnt_t Y_LO = cnt_t'(IMG_Y0);
    localparam cnt_t Y_HI = cnt_t'(IMG_Y0 + IMG_H);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_n;
    logic             pix_en;

    cnt_t     h_cnt;
    cnt_t     h_nxt;
    cnt_t     v_cnt;
    cnt_t     v_nxt;
    logic     h_wrap;
    h_phase_e h_ph;
    h_phase_e h_ph_n;
    v_phase_e v_ph;
    v_phase_e v_ph_n;

    cnt_t     hx;
    cnt_t     vy;
    fb_addr_t rd_addr;
    rgb12_t   rd_data;
    scan_t    s1_n;
    scan_t    s1_q;

    rgb12_t   wr_data;
    logic     wr_en;
    rgb12_t   rgb_n;
    rgb12_t   rgb_q;
    logic     hs_q;
    logic     vs_q;
    logic     de_q;
    logic     fs_q;
    logic     unused_bits;

    assign pix_en = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
            h_ph  <= H_ACT;
            v_ph  <= V_ACT;
        end else begin
            div_q <= div_n;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            h_ph  <= h_ph_n;
            v_ph  <= v_ph_n;
        end
    end

    // Phases track the counters; each changes on the last count of a phase.
    always_comb begin
        div_n  = div_q + 1'b1;
        h_nxt  = h_cnt;
        v_nxt  = v_cnt;
        h_ph_n = h_ph;
        v_ph_n = v_ph;
        h_wrap = (h_cnt == H_LAST);
        if (pix_en) begin
            div_n = '0;
            h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
            unique case (h_ph)
                H_ACT: if (h_cnt == H_ACT_LAST) h_ph_n = H_FPO;
                H_FPO: if (h_cnt == H_FP_LAST)  h_ph_n = H_SYN;
                H_SYN: if (h_cnt == H_SYN_LAST) h_ph_n = H_BPO;
                H_BPO: if (h_wrap)              h_ph_n = H_ACT;
            endcase
            if (h_wrap) begin
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                unique case (v_ph)
                    V_ACT: if (v_cnt == V_ACT_LAST) v_ph_n = V_FPO;
                    V_FPO: if (v_cnt == V_FP_LAST)  v_ph_n = V_SYN;
                    V_SYN: if (v_cnt == V_SYN_LAST) v_ph_n = V_BPO;
                    V_BPO: if (v_cnt == V_LAST)     v_ph_n = V_ACT;
                endcase
            end
        end
    end

    always_comb begin
        hx       = h_cnt - X_LO;
        vy       = v_cnt - Y_LO;
        rd_addr  = {vy[7:0], hx[7:0]};
        s1_n.de  = (h_ph == H_ACT) && (v_ph == V_ACT);
        s1_n.hs  = (h_ph != H_SYN);
        s1_n.vs  = (v_ph != V_SYN);
        s1_n.fs  = (h_cnt == '0) && (v_cnt == '0);
        s1_n.win = s1_n.de
                 && (h_cnt >= X_LO) && (h_cnt < X_HI)
                 && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
    end

    assign wr_en   = bus.pix_valid && !rst;
    assign wr_data = pack_rgb(bus.pix_r[15:12],
                              bus.pix_g[15:12],
                              bus.pix_b[15:12]);

    fb_dpram #(
        .AW (16),
        .DW (12)
    ) u_fb (
        .clk   (clk),
        .we    (wr_en),
        .waddr (bus.pix_addr),
        .wdata (wr_data),
        .re    (pix_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // win already implies de, so at most one arm is taken.
    always_comb begin
        rgb_n = rgb12_t'(BORDER_RGB);
        unique case (1'b1)
            s1_q.win: rgb_n = rd_data;
            !s1_q.de: rgb_n = '0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= SCAN_IDLE;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            rgb_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= pix_en && s1_q.fs;
            if (pix_en) begin
                s1_q  <= s1_n;
                hs_q  <= s1_q.hs;
                vs_q  <= s1_q.vs;
                de_q  <= s1_q.de;
                rgb_q <= rgb_n;
            end
        end
    end

    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_de      = de_q;
    assign bus.vga_r       = rgb_q.r;
    assign bus.vga_g       = rgb_q.g;
    assign bus.vga_b       = rgb_q.b;
    assign bus.frame_start = fs_q;

    assign unused_bits = ^{bus.pix_r[11:0], bus.pix_g[11:0],
                           bus.pix_b[11:0], hx[11:8], vy[11:8]};

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: scoreboard bench for vga_fb_scanout on a reduced
// raster, checked every clock against a position-based pixel model.
module tb_vga_fb_scanout;
    import vga_pkg::*;

    localparam int PD = 2;
    localparam int HA = 262;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 5;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int X0 = 4;
    localparam int Y0 = 1;
    localparam logic [11:0] BRD = 12'h5A3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [11:0] rgb;
        logic        known;
    } pins_t;

    localparam pins_t RST_PINS = '{hs: 1'b1, vs: 1'b1, de: 1'b0,
                                   fs: 1'b0, rgb: 12'h000, known: 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_fb_scanout_if bus();

    vga_fb_scanout #(
        .PIX_DIV    (PD),
        .H_ACTIVE   (HA),
        .H_FP       (HF),
        .H_SYNC     (HS),
        .H_BP       (HB),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB),
        .IMG_X0     (X0),
        .IMG_Y0     (Y0),
        .BORDER_RGB (BRD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pins_t       exp_q[$];
    logic [11:0] fb_m [65536];
    bit          known_m [65536];
    int          m_div = 0;
    int          m_pos = 0;
    bit          m_on = 0;
    bit          pend_ok = 0;
    pins_t       pend;
    pins_t       cur = RST_PINS;
    int          vectors = 0;
    int          miscompares = 0;
    int          collisions = 0;

    function automatic int addr_at(int pos);
        int h = pos % HT;
        int v = pos / HT;
        if (h < HA && v < VA && h >= X0 && h < X0 + 256
            && v >= Y0 && v < Y0 + 256)
            return ((v - Y0) << 8) | (h - X0);
        return -1;
    endfunction

    function automatic pins_t pixel_at(int pos);
        pins_t p;
        int h = pos % HT;
        int v = pos / HT;
        int a = addr_at(pos);
        p.de    = (h < HA) && (v < VA);
        p.hs    = !(h >= HA + HF && h < HA + HF + HS);
        p.vs    = !(v >= VA + VF && v < VA + VF + VS);
        p.fs    = (pos == 0);
        p.rgb   = 12'h000;
        p.known = 1'b1;
        if (p.de && a >= 0) begin
            p.rgb   = fb_m[a];
            p.known = known_m[a];
        end else if (p.de) begin
            p.rgb = BRD;
        end
        return p;
    endfunction

    always @(posedge clk) begin : model
        pins_t e;
        if (rst) begin
            m_on    = 1;
            m_div   = 0;
            m_pos   = 0;
            pend_ok = 0;
            cur     = RST_PINS;
            e       = cur;
        end else begin
            e    = cur;
            e.fs = 1'b0;
            if (m_div == PD - 1) begin
                cur     = pend_ok ? pend : RST_PINS;
                pend    = pixel_at(m_pos);
                pend_ok = 1;
                m_pos   = (m_pos + 1) % FT;
                e       = cur;
            end
            m_div = (m_div + 1) % PD;
            if (bus.pix_valid) begin
                fb_m[bus.pix_addr]    = {bus.pix_r[15:12], bus.pix_g[15:12],
                                         bus.pix_b[15:12]};
                known_m[bus.pix_addr] = 1'b1;
            end
        end
        if (m_on)
            exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        pins_t e;
        logic [11:0] got;
        bit bad;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.vga_r, bus.vga_g, bus.vga_b};
            vectors++;
            bad = (bus.vga_hs !== e.hs) || (bus.vga_vs !== e.vs)
                || (bus.vga_de !== e.de) || (bus.frame_start !== e.fs)
                || (e.known && got !== e.rgb);
            if (bad) begin
                miscompares++;
                $display("FAIL pins @%0t: got hs=%b vs=%b de=%b fs=%b rgb=%h want hs=%b vs=%b de=%b fs=%b rgb=%h",
                         $time, bus.vga_hs, bus.vga_vs, bus.vga_de,
                         bus.frame_start, got, e.hs, e.vs, e.de, e.fs,
                         e.rgb);
            end
        end
    end

    initial begin : watchdog
        #20ms;
        $display("FAIL timeout: simulation did not finish");
        $finish;
    end

    task automatic cyc(input bit v, input int a,
                       input logic [15:0] r, input logic [15:0] g,
                       input logic [15:0] b);
        bus.pix_valid = v;
        bus.pix_addr  = 16'(a);
        bus.pix_r     = r;
        bus.pix_g     = g;
        bus.pix_b     = b;
        @(negedge clk);
    endtask

    task automatic run_quiet(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        int a;
        logic [11:0] inv;
        bus.pix_valid = 1'b0;
        bus.pix_addr  = '0;
        bus.pix_r     = '0;
        bus.pix_g     = '0;
        bus.pix_b     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        if (bus.vga_hs !== 1'b1 || bus.vga_vs !== 1'b1
            || bus.vga_de !== 1'b0 || bus.frame_start !== 1'b0
            || {bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset state: hs=%b vs=%b de=%b fs=%b rgb=%h",
                     bus.vga_hs, bus.vga_vs, bus.vga_de, bus.frame_start,
                     {bus.vga_r, bus.vga_g, bus.vga_b});
        end
        rst = 1'b0;

        for (int i = 0; i < 65536; i++)
            cyc(1'b1, i, 16'($urandom), 16'($urandom), 16'($urandom));

        for (int i = 0; i < FT * PD; i++)
            cyc($urandom_range(0, 3) == 0,
                ($urandom_range(0, 7) << 8) | $urandom_range(0, 255),
                16'($urandom), 16'($urandom), 16'($urandom));

        for (int i = 0; i < FT * PD; i++) begin
            a = addr_at(m_pos);
            if (m_div == PD - 1 && a >= 0) begin
                collisions++;
                cyc(1'b1, a, 16'($urandom), 16'($urandom), 16'($urandom));
            end else begin
                cyc(1'b0, 0, 16'h0, 16'h0, 16'h0);
            end
        end
        if (collisions == 0) begin
            miscompares++;
            $display("FAIL no read/write collisions were generated");
        end

        cyc(1'b1, 16'h0000, 16'hF000, 16'h0000, 16'hA000);
        cyc(1'b1, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        cyc(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_quiet(FT * PD);

        for (int i = 0; i < FT * PD && m_pos != 2 * HT + 150; i++)
            cyc(1'b0, 0, 16'h0, 16'h0, 16'h0);
        if (m_pos != 2 * HT + 150) begin
            miscompares++;
            $display("FAIL wait for scan position %0d expired at %0d",
                     2 * HT + 150, m_pos);
        end
        a   = (1 << 8) | 20;
        inv = ~fb_m[a];
        rst = 1'b1;
        cyc(1'b1, a, {inv[11:8], 12'h0}, {inv[7:4], 12'h0},
            {inv[3:0], 12'h0});
        rst = 1'b0;
        run_quiet(FT * PD + 8);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        if (miscompares == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule
